// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline hazard/stall controller for the 5-stage core.
// Registers ALU operand forwarding selects, detects load-use hazards, flushes
// IF/ID on taken branches and holds the pipe while the multi-cycle MDU runs.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   id_rs1, id_rs2             source registers of the instruction in ID
//   id_use_rs1, id_use_rs2     ID instruction actually reads rs1 / rs2
//   ex_rd, ex_regwrite         EX destination and write enable
//   ex_is_load                 EX instruction is a load
//   mem_rd, mem_regwrite       MEM destination and write enable
//   branch_taken               EX resolved a taken branch/jump
//   mdu_start, mdu_done        MDU issue from EX / MDU result valid
//   stall_if, stall_id         hold PC + IF/ID / hold ID instruction (same cycle)
//   stall_ex                   hold EX/MEM while the MDU occupies EX
//   bubble_ex, bubble_mem      inject NOP into ID/EX / EX/MEM
//   flush_ifid                 clear IF/ID to NOP
//   fwd_rs1, fwd_rs2           operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   mdu_timeout                sticky error, MDU exceeded MDU_TIMEOUT cycles
//   stall_cycles               saturating count of cycles with stall_id=1
module hazard_sequencer #(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_is_load,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             mdu_done,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             bubble_ex,
  output logic             bubble_mem,
  output logic             flush_ifid,
  output logic [1:0]       fwd_rs1,
  output logic [1:0]       fwd_rs2,
  output logic             mdu_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned TW = $clog2(MDU_TIMEOUT + 1);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {RUN, MDU_WAIT} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    wcnt_q, wcnt_d;
  logic             to_q, to_d;
  logic [1:0]       fwd1_q, fwd1_d;
  logic [1:0]       fwd2_q, fwd2_d;
  logic [CNT_W-1:0] sc_q, sc_d;

  // Source/destination matches; x0 never matches so it never stalls or forwards
  logic rs1_ex, rs2_ex, rs1_mem, rs2_mem, load_use;

  assign rs1_ex   = id_use_rs1 && (id_rs1 != 5'd0) && ex_regwrite  && (ex_rd  == id_rs1);
  assign rs2_ex   = id_use_rs2 && (id_rs2 != 5'd0) && ex_regwrite  && (ex_rd  == id_rs2);
  assign rs1_mem  = id_use_rs1 && (id_rs1 != 5'd0) && mem_regwrite && (mem_rd == id_rs1);
  assign rs2_mem  = id_use_rs2 && (id_rs2 != 5'd0) && mem_regwrite && (mem_rd == id_rs2);
  assign load_use = ex_is_load && (rs1_ex || rs2_ex);

  // State and bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      to_q    <= 1'b0;
      fwd1_q  <= FWD_RF;
      fwd2_q  <= FWD_RF;
      sc_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      to_q    <= to_d;
      fwd1_q  <= fwd1_d;
      fwd2_q  <= fwd2_d;
      sc_q    <= sc_d;
    end
  end

  // Next state and same-cycle pipeline controls
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    to_d       = to_q;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    stall_ex   = 1'b0;
    bubble_ex  = 1'b0;
    bubble_mem = 1'b0;
    flush_ifid = 1'b0;

    case (state_q)
      RUN: begin
        if (branch_taken) begin
          flush_ifid = 1'b1;
          bubble_ex  = 1'b1;
        end else if (mdu_start) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          state_d  = MDU_WAIT;
          wcnt_d   = TW'(1);
        end else if (load_use) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (mdu_done) begin
          state_d = RUN;
        end else begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          stall_ex   = 1'b1;
          bubble_mem = 1'b1;
          // Stalls stay up through the expiring cycle and drop on the next one
          if (wcnt_q == TW'(MDU_TIMEOUT)) begin
            to_d    = 1'b1;
            state_d = RUN;
          end else begin
            wcnt_d = wcnt_q + TW'(1);
          end
        end
      end
      default: state_d = RUN;
    endcase

    if (reset) begin
      stall_if   = 1'b0;
      stall_id   = 1'b0;
      stall_ex   = 1'b0;
      bubble_ex  = 1'b0;
      bubble_mem = 1'b0;
      flush_ifid = 1'b0;
    end
  end

  // Forwarding selects track the instruction leaving ID; EX beats MEM, loads
  // in EX cannot forward (that case stalls instead)
  always_comb begin
    fwd1_d = fwd1_q;
    fwd2_d = fwd2_q;
    if (flush_ifid) begin
      fwd1_d = FWD_RF;
      fwd2_d = FWD_RF;
    end else if (!stall_id) begin
      fwd1_d = (rs1_ex && !ex_is_load) ? FWD_EX : (rs1_mem ? FWD_MEM : FWD_RF);
      fwd2_d = (rs2_ex && !ex_is_load) ? FWD_EX : (rs2_mem ? FWD_MEM : FWD_RF);
    end
  end

  // Saturating stall counter
  always_comb begin
    sc_d = sc_q;
    if (stall_id && (sc_q != {CNT_W{1'b1}})) begin
      sc_d = sc_q + CNT_W'(1);
    end
  end

  assign fwd_rs1      = fwd1_q;
  assign fwd_rs2      = fwd2_q;
  assign mdu_timeout  = to_q;
  assign stall_cycles = sc_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
module tb_hazard_sequencer;

  localparam int unsigned TO = 8;
  localparam int unsigned CW = 5;
  localparam int unsigned SC_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    id_rs1, id_rs2, ex_rd, mem_rd;
  logic          id_use_rs1, id_use_rs2, ex_regwrite, ex_is_load, mem_regwrite;
  logic          branch_taken, mdu_start, mdu_done;
  logic          stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_ifid;
  logic [1:0]    fwd_rs1, fwd_rs2;
  logic          mdu_timeout;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_sequencer #(.MDU_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .branch_taken(branch_taken), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .bubble_ex(bubble_ex), .bubble_mem(bubble_mem), .flush_ifid(flush_ifid),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .mdu_timeout(mdu_timeout), .stall_cycles(stall_cycles)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pipeline view in terms of "MDU busy with N cycles left"
  bit         m_valid = 1'b0;
  bit         m_busy;
  int         m_left;
  bit         m_to;
  logic [1:0] m_f1, m_f2;
  int         m_sc;
  logic [5:0] m_st;   // {stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_ifid}
  logic [5:0] got_st;

  function automatic bit hit(logic u, logic [4:0] rs, logic w, logic [4:0] rd);
    return u && (rs != 5'd0) && w && (rd == rs);
  endfunction

  function automatic logic [1:0] fsel(logic u, logic [4:0] rs);
    if (hit(u, rs, ex_regwrite, ex_rd) && !ex_is_load) return 2'b01;
    if (hit(u, rs, mem_regwrite, mem_rd)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_expect();
    bit lu;
    lu = ex_is_load && (hit(id_use_rs1, id_rs1, ex_regwrite, ex_rd) ||
                        hit(id_use_rs2, id_rs2, ex_regwrite, ex_rd));
    if (reset)             m_st = 6'b000000;
    else if (m_busy)       m_st = mdu_done ? 6'b000000 : 6'b111010;
    else if (branch_taken) m_st = 6'b000101;
    else if (mdu_start)    m_st = 6'b110000;
    else if (lu)           m_st = 6'b110100;
    else                   m_st = 6'b000000;
  endtask

  task automatic model_update();
    if (reset) begin
      m_valid = 1'b1; m_busy = 1'b0; m_left = 0; m_to = 1'b0;
      m_f1 = 2'b00; m_f2 = 2'b00; m_sc = 0;
      return;
    end
    if (m_st[0]) begin
      m_f1 = 2'b00; m_f2 = 2'b00;
    end else if (!m_st[4]) begin
      m_f1 = fsel(id_use_rs1, id_rs1);
      m_f2 = fsel(id_use_rs2, id_rs2);
    end
    if (m_st[4] && m_sc < int'(SC_MAX)) m_sc++;
    if (m_busy) begin
      if (mdu_done) m_busy = 1'b0;
      else if (m_left == 1) begin m_to = 1'b1; m_busy = 1'b0; end
      else m_left--;
    end else if (!branch_taken && mdu_start) begin
      m_busy = 1'b1; m_left = TO;
    end
  endtask

  // One clock: called at negedge with inputs already applied
  task automatic step();
    #1;
    got_st = {stall_if, stall_id, stall_ex, bubble_ex, bubble_mem, flush_ifid};
    model_expect();
    chk("model_ctrl", got_st, m_st);
    if (m_valid) begin
      chk("model_fwd", {fwd_rs1, fwd_rs2}, {m_f1, m_f2});
      chk("model_timeout", mdu_timeout, m_to);
      chk("model_stall_cycles", stall_cycles, m_sc);
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = 0; ex_regwrite = 0; ex_is_load = 0; mem_rd = 0; mem_regwrite = 0;
    branch_taken = 0; mdu_start = 0; mdu_done = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] exrd;
    logic       exw, exl;
    logic [4:0] memrd;
    logic       memw, br, ms;
    logic [5:0] st;
    logic [1:0] f1, f2;
  } vec_t;

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b01, 2'b00};
    tbl[1]  = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 6'b110100, 2'b00, 2'b00};
    tbl[2]  = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 6'b000101, 2'b00, 2'b00};
    tbl[3]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00};
    tbl[4]  = '{5'd3, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 6'b000000, 2'b10, 2'b10};
    tbl[5]  = '{5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 6'b000000, 2'b01, 2'b00};
    tbl[6]  = '{5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00};
    tbl[7]  = '{5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 6'b110000, 2'b00, 2'b00};
    tbl[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 6'b000101, 2'b00, 2'b00};
    tbl[9]  = '{5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00};
    tbl[10] = '{5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00};
    tbl[11] = '{5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 6'b000000, 2'b00, 2'b00};
    tbl[12] = '{5'd8, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 6'b110100, 2'b00, 2'b00};
    tbl[13] = '{5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 6'b000000, 2'b01, 2'b01};
    tbl[14] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 6'b000101, 2'b00, 2'b00};

    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    do_reset();
    chk("reset_fwd", {fwd_rs1, fwd_rs2}, 4'b0000);
    chk("reset_timeout", mdu_timeout, 1'b0);
    chk("reset_stall_cycles", stall_cycles, 0);

    // Single-cycle vectors from a freshly reset pipeline
    for (int i = 0; i < 15; i++) begin
      do_reset();
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2;
      id_use_rs1 = tbl[i].u1; id_use_rs2 = tbl[i].u2;
      ex_rd = tbl[i].exrd; ex_regwrite = tbl[i].exw; ex_is_load = tbl[i].exl;
      mem_rd = tbl[i].memrd; mem_regwrite = tbl[i].memw;
      branch_taken = tbl[i].br; mdu_start = tbl[i].ms;
      step();
      chk($sformatf("tbl%0d_ctrl", i), got_st, tbl[i].st);
      chk($sformatf("tbl%0d_fwd1", i), fwd_rs1, tbl[i].f1);
      chk($sformatf("tbl%0d_fwd2", i), fwd_rs2, tbl[i].f2);
    end

    // Load-use stall, then the load sits in MEM and forwards from MEM/WB
    do_reset();
    ex_rd = 5'd7; ex_regwrite = 1; ex_is_load = 1; id_rs2 = 5'd7; id_use_rs2 = 1;
    step();
    chk("lu_stall", got_st, 6'b110100);
    ex_rd = 5'd0; ex_regwrite = 0; ex_is_load = 0; mem_rd = 5'd7; mem_regwrite = 1;
    step();
    chk("lu_released", got_st, 6'b000000);
    chk("lu_fwd2_mem", fwd_rs2, 2'b10);

    // MDU finishing after four wait cycles; branches ignored while waiting
    do_reset();
    mdu_start = 1;
    step();
    chk("mdu_issue", got_st, 6'b110000);
    mdu_start = 0; branch_taken = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("mdu_wait%0d", i), got_st, 6'b111010);
    end
    branch_taken = 0; mdu_done = 1;
    step();
    chk("mdu_done_ctrl", got_st, 6'b000000);
    chk("mdu_stall_cycles", stall_cycles, 5);
    mdu_done = 0;
    step();
    chk("mdu_back_run", got_st, 6'b000000);
    chk("mdu_no_timeout", mdu_timeout, 1'b0);

    // MDU never completes: timeout after TO wait cycles, sticky afterwards
    do_reset();
    mdu_start = 1;
    step();
    mdu_start = 0;
    for (int i = 0; i < int'(TO); i++) begin
      step();
      chk($sformatf("to_wait%0d", i), got_st, 6'b111010);
      if (i < int'(TO) - 1) chk($sformatf("to_early%0d", i), mdu_timeout, 1'b0);
    end
    chk("to_flag", mdu_timeout, 1'b1);
    chk("to_stall_cycles", stall_cycles, TO + 1);
    step();
    chk("to_back_run", got_st, 6'b000000);
    mdu_start = 1;
    step();
    mdu_start = 0; mdu_done = 1;
    step();
    mdu_done = 0;
    chk("to_sticky", mdu_timeout, 1'b1);

    // Reset while in MDU_WAIT with a non-zero forwarding select
    do_reset();
    mem_rd = 5'd3; mem_regwrite = 1; id_rs1 = 5'd3; id_use_rs1 = 1;
    step();
    chk("rst_pre_fwd", fwd_rs1, 2'b10);
    mdu_start = 1;
    step();
    mdu_start = 0;
    step();
    step();
    reset = 1;
    step();
    chk("rst_mid_ctrl", got_st, 6'b000000);
    chk("rst_mid_fwd", fwd_rs1, 2'b00);
    chk("rst_mid_sc", stall_cycles, 0);
    reset = 0;
    clear_inputs();
    step();
    chk("rst_mid_run", got_st, 6'b000000);

    // Persistent load-use saturates the counter
    do_reset();
    ex_rd = 5'd9; ex_regwrite = 1; ex_is_load = 1; id_rs1 = 5'd9; id_use_rs1 = 1;
    for (int i = 0; i < 40; i++) step();
    chk("sat_count", stall_cycles, SC_MAX);
    chk("sat_ctrl", got_st, 6'b110100);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 199) == 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom);
      id_use_rs2   = 1'($urandom);
      ex_rd        = 5'($urandom_range(0, 3));
      ex_regwrite  = 1'($urandom);
      ex_is_load   = 1'($urandom);
      mem_rd       = 5'($urandom_range(0, 3));
      mem_regwrite = 1'($urandom);
      branch_taken = ($urandom_range(0, 7) == 0);
      mdu_start    = ($urandom_range(0, 7) == 0);
      mdu_done     = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
